approx_mult_pipe: RTL
=====================

Name: approx_mult_pipe

Overview:
- Parametrised, pipelined unsigned W x W multiplier with a per-transaction exact/approximate mode.
- In approximate mode, the low L partial-product rows (multiplier bits x[L-1:0]) keep only the bits at or above column TRUNC. The upper rows are always exact.
- Two register stages with valid/ready handshakes on input and output, full throughput, and a saturating count of completed approximate results.
- Drop-in replacement for the fixed 8x8 combinational approximate multipliers in accelerator datapaths that need back-pressure.

Parameters:
- W, 8, operand width in bits (2..16).
- L, 4, number of approximated low multiplier rows (0..W); L=0 makes approximate equal exact.
- TRUNC, 6, lowest kept column in approximated rows (0..2W-2).
- COMP, 0, constant added to the result in approximate mode only (compensation), width 2W.
- CW, 16, width of approx_count.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  operand transfer request
- in_ready  out  1  block can accept operands this cycle
- in_x  in  W  multiplier (rows)
- in_y  in  W  multiplicand
- in_mode  in  1  0 = exact, 1 = approximate
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_z  out  2W  product
- out_mode  out  1  mode the result was computed in
- approx_count  out  CW  completed approximate transfers, saturating

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high. Port names are clk and rst.
- Reset values: s1_valid=0, out_valid=0, out_z=0, out_mode=0, approx_count=0. in_ready=1 in the cycle after reset.
- Reset mid-operation discards all in-flight transactions; nothing is emitted afterwards.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- Stage 1, registered on input transfer:
  - hi = in_y * in_x[W-1:L], width 2W-L.
  - lo = exact sum of x[i]&y[j]<<(i+j) for i<L when mode=0. When mode=1, the sum is restricted to terms with i+j>=TRUNC.
  - mode is registered with the operands.
- Stage 2 / output: out_z = (hi<<L) + lo + (mode ? COMP : 0), computed modulo 2^(2W) and registered.
- Advance rules:
  - out stage loads when !out_valid || out_ready.
  - Stage 1 loads when !s1_valid || out stage loads.
  - in_ready = !s1_valid || (!out_valid || out_ready), combinational, with no dependency on in_valid.
- Latency and throughput: 2 cycles from input transfer to out_valid when not stalled; 1 transfer per cycle sustained.
- Stall: while out_valid && !out_ready, out_z and out_mode hold stable, and stage 1 holds if occupied. in_ready drops only when both stages are full and stalled.
- Bubbles: stage-valid clears when that stage's data moves on and no new data arrives.
- Simultaneous output transfer and stage-1 advance in the same cycle is allowed: the result is replaced, not lost.
- approx_count increments by 1 on each output transfer with out_mode=1, and saturates at 2^CW-1. Exact transfers leave it unchanged.
- Elaboration check: L>W or TRUNC>2W-2 is a fatal error.

Decomposition:
- Shared package approx_mult_pkg holds:
  - mode constants MODE_EXACT=0 and MODE_APPROX=1.
  - function keep_bit(i,j,L,TRUNC), returning whether a partial-product bit survives in approximate mode.
  - a reference-model function approx_product(x,y,mode,W,L,TRUNC,COMP), used by the bench.
- One sub-module approx_lowpart: combinational L-row masked partial-product summation. The top level keeps the handshake, pipeline and counter.

Test Plan:
- Defaults; x=8'hFF, y=8'hFF, mode=0 then mode=1, out_ready=1 -> out_z=65025 then 64784, each 2 cycles after its transfer, back-to-back. approx_count=1.
- Defaults; x=15, y=3, mode=1 -> out_z=0 (all low bits truncated). Same operands with mode=0 -> 45. x=16, y=200 in either mode -> 3200.
- Stream 20 random operand pairs with random modes while out_ready toggles pseudo-randomly -> results in order, each matching approx_product. No loss or duplication; out_z stable during stalls; in_ready=0 only when both stages are full and out_ready=0.
- Hold out_ready=0 after 2 transfers -> in_ready=0 on the third cycle. Raise out_ready -> one result per cycle with no bubble.
- Assert rst while 2 transactions are in flight -> next cycle out_valid=0, approx_count=0, in_ready=1. No stale result ever appears.
- CW=2, 5 approximate transfers -> approx_count sequence 1,2,3,3,3. Parameters L=0 and COMP=3 -> mode=1 result equals exact product + 3.

Source files
------------

// File: rtl/approx_mult_pipe_pkg.sv
// Shared definitions for the approximate multiplier: mode encoding, the
// partial-product keep rule and a bit-level reference product.
package approx_mult_pkg;

    localparam logic MODE_EXACT  = 1'b0;
    localparam logic MODE_APPROX = 1'b1;

    // A partial-product bit x[i]&y[j] survives approximation when it sits in an
    // exact (upper) row or lands at or above the truncation column.
    function automatic logic keep_bit(input int i, input int j, input int l, input int trunc);
        return (i >= l) || ((i + j) >= trunc);
    endfunction

    // Bit-by-bit product in either mode, reduced modulo 2^(2w). Widths up to 16.
    function automatic logic [31:0] approx_product(input logic [15:0] x, input logic [15:0] y,
                                                   input logic mode, input int w, input int l,
                                                   input int trunc, input logic [31:0] comp);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < w; i++) begin
            for (int j = 0; j < w; j++) begin
                if (x[i] && y[j] && (mode == MODE_EXACT || keep_bit(i, j, l, trunc))) begin
                    acc = acc + (32'd1 << (i + j));
                end
            end
        end
        if (mode == MODE_APPROX) begin
            acc = acc + comp;
        end
        if (w < 16) begin
            acc = acc & ((32'd1 << (2 * w)) - 32'd1);
        end
        return acc;
    endfunction

endpackage

// File: rtl/approx_mult_pipe_lowpart.sv
// Sum of the low L partial-product rows, with columns below TRUNC masked off
// in approximate mode.
module approx_lowpart
    import approx_mult_pkg::*;
#(
    parameter int W = 8,
    parameter int L = 4,
    parameter int TRUNC = 6,
    localparam int LW = (L == 0) ? 1 : L
) (
    input  logic [LW-1:0]  x,
    input  logic [W-1:0]   y,
    input  logic           mode,
    output logic [2*W-1:0] lo
);

    logic [2*W-1:0] row;

    // Accumulate each low row, shifted to its weight; the mask is constant per row/column.
    always_comb begin
        lo  = '0;
        row = '0;
        for (int i = 0; i < L; i++) begin
            row = '0;
            for (int j = 0; j < W; j++) begin
                if (mode == MODE_EXACT || keep_bit(i, j, L, TRUNC)) begin
                    row[j] = y[j];
                end
            end
            if (x[i]) begin
                lo = lo + (row << i);
            end
        end
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// Two-stage pipelined W x W multiplier with per-transaction exact/approximate
// mode, valid/ready on both sides, and a saturating approximate-result counter.
//
// Handshake: a transfer happens on a rising edge where valid && ready. valid,
// once raised, holds with its data until the transfer; in_ready does not look
// at in_valid. Stage 1 holds the upper-row product and the low-row sum; the
// output stage holds the final sum.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int W = 8,
    parameter int L = 4,
    parameter int TRUNC = 6,
    parameter logic [2*W-1:0] COMP = '0,
    parameter int CW = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_y,
    input  logic           in_mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] out_z,
    output logic           out_mode,
    output logic [CW-1:0]  approx_count
);

    localparam int HW = 2 * W - L;
    localparam int LW = (L == 0) ? 1 : L;

    if (W < 2 || W > 16 || L > W || TRUNC > 2 * W - 2) begin : g_param_check
        $fatal(1, "approx_mult_pipe: illegal parameters W=%0d L=%0d TRUNC=%0d", W, L, TRUNC);
    end

    logic           s1_valid;
    logic [HW-1:0]  s1_hi;
    logic [2*W-1:0] s1_lo;
    logic           s1_mode;

    logic           out_load;
    logic [2*W-1:0] x_hi;
    logic [2*W-1:0] hi_prod;
    logic [2*W-1:0] lo_next;
    logic [2*W-1:0] hi_ext;
    logic [2*W-1:0] z_next;

    // Output stage may take new data when empty or being drained this cycle.
    assign out_load = !out_valid || out_ready;
    assign in_ready = !s1_valid || out_load;

    // Upper rows are always exact: y times the multiplier bits above L.
    assign x_hi    = {{W{1'b0}}, in_x} >> L;
    assign hi_prod = x_hi * {{W{1'b0}}, in_y};

    approx_lowpart #(
        .W     (W),
        .L     (L),
        .TRUNC (TRUNC)
    ) u_lowpart (
        .x    (in_x[LW-1:0]),
        .y    (in_y),
        .mode (in_mode),
        .lo   (lo_next)
    );

    // Recombine the two halves and add compensation for approximate results.
    assign hi_ext = (2 * W)'(s1_hi) << L;
    assign z_next = hi_ext + s1_lo + ((s1_mode == MODE_APPROX) ? COMP : '0);

    // Stage 1: capture operands' partial results whenever it can advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_hi    <= '0;
            s1_lo    <= '0;
            s1_mode  <= MODE_EXACT;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_hi   <= hi_prod[HW-1:0];
                s1_lo   <= lo_next;
                s1_mode <= in_mode;
            end
        end
    end

    // Output stage: take the stage-1 result, or empty out as a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_z     <= '0;
            out_mode  <= MODE_EXACT;
        end else if (out_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_z    <= z_next;
                out_mode <= s1_mode;
            end
        end
    end

    // Count approximate results as they leave, holding at the maximum.
    always_ff @(posedge clk) begin
        if (rst) begin
            approx_count <= '0;
        end else if (out_valid && out_ready && out_mode == MODE_APPROX
                     && approx_count != {CW{1'b1}}) begin
            approx_count <= approx_count + 1'b1;
        end
    end

endmodule
